// File: rtl/fixed_pt_log_sub.sv
// One shift-add exponent iteration step: registered -ln(1-2^-i) constant and an 8.8 subtractor.
// Build option FIXED_PT_SAT_EN clamps the difference on signed overflow; otherwise it wraps.
module fixed_pt_log_sub #(
    parameter int XLEN_PIXEL = 8,
    parameter int IDX_W      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IDX_W-1:0]        i,
    input  logic [2*XLEN_PIXEL-1:0] a,
    output logic [2*XLEN_PIXEL-1:0] log_val,
    output logic [2*XLEN_PIXEL-1:0] out,
    output logic                    neg,
    output logic                    ovf
);

    localparam int W   = 2 * XLEN_PIXEL;
    localparam int MSB = W - 1;

    logic [W-1:0] r_log_val;
    logic [W-1:0] w_raw_diff;
    logic [W-1:0] w_out;
    logic         w_ovf;

    // Constants round(256 * -ln(1 - 2^-i)), half-up; i=0 is the infinite term, saturated.
    function automatic logic [W-1:0] log_lookup(input logic [IDX_W-1:0] idx);
        logic [W-1:0] v;
        case (idx)
            IDX_W'(0): v = W'(16'hFFFF);
            IDX_W'(1): v = W'(16'h00B1);
            IDX_W'(2): v = W'(16'h004A);
            IDX_W'(3): v = W'(16'h0022);
            IDX_W'(4): v = W'(16'h0011);
            IDX_W'(5): v = W'(16'h0008);
            IDX_W'(6): v = W'(16'h0004);
            IDX_W'(7): v = W'(16'h0002);
            IDX_W'(8): v = W'(16'h0001);
            IDX_W'(9): v = W'(16'h0001);
            default:   v = W'(16'h0000);
        endcase
        return v;
    endfunction

    // Log-constant register; reset has priority over the lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_log_val <= W'(16'h0000);
        end else begin
            r_log_val <= log_lookup(i);
        end
    end

    assign w_raw_diff = a - r_log_val;
    assign w_ovf      = (a[MSB] != r_log_val[MSB]) && (w_raw_diff[MSB] != a[MSB]);

    // Difference result: wrap by default, clamp toward the sign of a when saturation is built in.
    always_comb begin
        w_out = w_raw_diff;
`ifdef FIXED_PT_SAT_EN
        if (w_ovf) begin
            if (a[MSB]) begin
                w_out = {1'b1, {(W-1){1'b0}}};
            end else begin
                w_out = {1'b0, {(W-1){1'b1}}};
            end
        end else begin
            w_out = w_raw_diff;
        end
`else
        w_out = w_raw_diff;
`endif
    end

    assign log_val = r_log_val;
    assign out     = w_out;
    assign neg     = w_out[MSB];
    assign ovf     = w_ovf;

endmodule

// File: tb/tb_fixed_pt_log_sub.sv
// Directed self-checking bench for fixed_pt_log_sub; expectations follow FIXED_PT_SAT_EN when defined.
module tb_fixed_pt_log_sub;

    logic        clk;
    logic        rst;
    logic [4:0]  i;
    logic [15:0] a;
    logic [15:0] log_val;
    logic [15:0] out;
    logic        neg;
    logic        ovf;

    int n_checks;
    int n_errors;

    logic [15:0] exp_tab [0:12];

    fixed_pt_log_sub #(.XLEN_PIXEL(8), .IDX_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .a       (a),
        .log_val (log_val),
        .out     (out),
        .neg     (neg),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_tab[0]  = 16'hFFFF; exp_tab[1]  = 16'h00B1; exp_tab[2]  = 16'h004A;
        exp_tab[3]  = 16'h0022; exp_tab[4]  = 16'h0011; exp_tab[5]  = 16'h0008;
        exp_tab[6]  = 16'h0004; exp_tab[7]  = 16'h0002; exp_tab[8]  = 16'h0001;
        exp_tab[9]  = 16'h0001; exp_tab[10] = 16'h0000; exp_tab[11] = 16'h0000;
        exp_tab[12] = 16'h0000;

        // Reset state
        rst = 1'b1; i = 5'd1; a = 16'h0123;
        tick(); tick();
        chk("rst_log", log_val, 16'h0000);
        chk("rst_out", out, 16'h0123);
        chk("rst_neg", {15'd0, neg}, 16'h0000);
        chk("rst_ovf", {15'd0, ovf}, 16'h0000);

        // Lookup sweep, out = -log_val with a = 0
        rst = 1'b0; a = 16'h0000;
        for (int k = 0; k <= 12; k++) begin
            i = 5'(k);
            tick();
            chk($sformatf("sweep_log_%0d", k), log_val, exp_tab[k]);
            chk($sformatf("sweep_out_%0d", k), out, 16'h0000 - exp_tab[k]);
        end
        chk("sweep_ovf", {15'd0, ovf}, 16'h0000);

        // Positive step and same-cycle response to a
        i = 5'd1; a = 16'h0300;
        tick();
        chk("pos_out", out, 16'h024F);
        chk("pos_neg", {15'd0, neg}, 16'h0000);
        chk("pos_ovf", {15'd0, ovf}, 16'h0000);
        a = 16'h0100;
        #1;
        chk("pos_a_comb", out, 16'h004F);

        // i change is not visible before the next edge
        i = 5'd2;
        #1;
        chk("lat_hold", log_val, 16'h00B1);
        a = 16'h0040;
        tick();
        chk("neg_out", out, 16'hFFF6);
        chk("neg_neg", {15'd0, neg}, 16'h0001);
        chk("neg_ovf", {15'd0, ovf}, 16'h0000);

        // Overflow on negative a
        i = 5'd1; a = 16'h8000;
        tick();
        chk("ovf_n_ovf", {15'd0, ovf}, 16'h0001);
`ifdef FIXED_PT_SAT_EN
        chk("ovf_n_out", out, 16'h8000);
        chk("ovf_n_neg", {15'd0, neg}, 16'h0001);
`else
        chk("ovf_n_out", out, 16'h7F4F);
        chk("ovf_n_neg", {15'd0, neg}, 16'h0000);
`endif

        // Overflow on positive a against the saturated i=0 term
        i = 5'd0; a = 16'h7FFF;
        tick();
        chk("ovf_p_ovf", {15'd0, ovf}, 16'h0001);
`ifdef FIXED_PT_SAT_EN
        chk("ovf_p_out", out, 16'h7FFF);
        chk("ovf_p_neg", {15'd0, neg}, 16'h0000);
`else
        chk("ovf_p_out", out, 16'h8000);
        chk("ovf_p_neg", {15'd0, neg}, 16'h0001);
`endif

        // Mid-run reset with i=3 streaming
        i = 5'd3; a = 16'h0100;
        tick();
        chk("mid_pre_log", log_val, 16'h0022);
        chk("mid_pre_out", out, 16'h00DE);
        rst = 1'b1;
        tick();
        chk("mid_rst_log", log_val, 16'h0000);
        chk("mid_rst_out", out, 16'h0100);
        rst = 1'b0;
        tick();
        chk("mid_post_log", log_val, 16'h0022);
        tick();
        chk("mid_hold_log", log_val, 16'h0022);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
